// File: rtl/sub_word_seq_if.sv
// sub_word_seq_if: request/response bundle for sub_word_seq.
//   master: key-schedule / cipher control (drives requests, accepts results)
//   slave : sub_word_seq itself
//   in_valid/in_ready  request handshake; in_word, in_rot, in_rcon request payload
//   out_valid/out_ready result handshake; out_word result payload
interface sub_word_seq_if #(
    parameter int BYTES = 4
);
    localparam int W = 8 * BYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_word;
    logic         in_rot;
    logic [7:0]   in_rcon;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_word;

    modport master (
        output in_valid, in_word, in_rot, in_rcon, out_ready,
        input  in_ready, out_valid, out_word
    );

    modport slave (
        input  in_valid, in_word, in_rot, in_rcon, out_ready,
        output in_ready, out_valid, out_word
    );
endinterface

// File: rtl/sub_word_seq.sv
// sub_word_seq: sequential SubWord with optional RotWord and Rcon XOR.
//   Substitutes every byte of a BYTES-wide word through LANES shared S-boxes,
//   LANES bytes per cycle (MSB byte first), over BEATS = BYTES/LANES cycles.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  sub_word_seq_if.slave (request in, result out, valid/ready each side)
//
// sbox: combinational AES S-box (multiplicative inverse in GF(2^8) followed by
//   the affine transform).
//   Ports: in_byte -> out_byte

module sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;
    logic [7:0] sq;

    // inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as required
    always_comb begin
        sq  = in_byte;
        inv = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
    end

    assign out_byte = inv
                    ^ {inv[6:0], inv[7]}
                    ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]}
                    ^ 8'h63;
endmodule

module sub_word_seq #(
    parameter int BYTES = 4,
    parameter int LANES = 1
) (
    input  logic           clk,
    input  logic           rst,
    sub_word_seq_if.slave  bus
);
    localparam int W      = 8 * BYTES;
    localparam int BEATS  = BYTES / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [W-1:0]      work_q, work_d;
    logic [7:0]        rcon_q, rcon_d;
    logic              out_valid_q, out_valid_d;
    logic [W-1:0]      out_word_q, out_word_d;

    logic [7:0]        sbox_in  [LANES];
    logic [7:0]        sbox_out [LANES];
    logic [W-1:0]      work_sub;
    logic [2*W-1:0]    in_dbl;

    // Bit offset of the byte handled by a lane in a given beat; byte 0 of the
    // sequence is the MSB byte of the word.
    function automatic int unsigned byte_lsb(input logic [BEAT_W-1:0] beat,
                                             input int unsigned      lane);
        int unsigned k;
        k = 32'(beat) * 32'(LANES) + lane;
        return 32'(W) - 32'd8 - 32'd8 * k;
    endfunction

    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            sbox_in[l] = work_q[byte_lsb(beat_q, l) +: 8];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox u_sbox (
            .in_byte  (sbox_in[g]),
            .out_byte (sbox_out[g])
        );
    end

    always_comb begin
        work_sub = work_q;
        for (int unsigned l = 0; l < LANES; l++) begin
            work_sub[byte_lsb(beat_q, l) +: 8] = sbox_out[l];
        end
    end

    // RotWord taken from a doubled word so the select also holds for BYTES == 1
    assign in_dbl = {bus.in_word, bus.in_word};

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        work_d      = work_q;
        rcon_d      = rcon_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    work_d  = bus.in_rot ? in_dbl[2*W-9 -: W] : bus.in_word;
                    rcon_d  = bus.in_rcon;
                    beat_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                work_d = work_sub;
                if (beat_q == LAST_BEAT) begin
                    out_word_d  = work_sub ^ {rcon_q, {(W-8){1'b0}}};
                    out_valid_d = 1'b1;
                    beat_d      = '0;
                    state_d     = DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            work_q      <= '0;
            rcon_q      <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            work_q      <= work_d;
            rcon_q      <= rcon_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
endmodule

// File: tb/tb_sub_word_seq.sv
// tb_sub_word_seq: drives three builds of sub_word_seq (BYTES=4 with LANES=1,2,4)
// and compares their results against a table-driven AES SubWord model.
module tb_sub_word_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [3];
    logic        in_rot    [3];
    logic [31:0] in_word   [3];
    logic [7:0]  in_rcon   [3];
    logic        out_ready [3];
    logic        in_ready_o  [3];
    logic        out_valid_o [3];
    logic [31:0] out_word_o  [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sub_word_seq_if #(.BYTES(4)) bus ();
        sub_word_seq #(.BYTES(4), .LANES(1 << g)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
        assign bus.in_valid   = in_valid[g];
        assign bus.in_word    = in_word[g];
        assign bus.in_rot     = in_rot[g];
        assign bus.in_rcon    = in_rcon[g];
        assign bus.out_ready  = out_ready[g];
        assign in_ready_o[g]  = bus.in_ready;
        assign out_valid_o[g] = bus.out_valid;
        assign out_word_o[g]  = bus.out_word;
    end

    localparam logic [127:0] SB_ROW [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [127:0] row;
        row = SB_ROW[x[7:4]];
        return row[8 * (15 - int'(x[3:0])) +: 8];
    endfunction

    function automatic logic [31:0] model(input logic [31:0] w, input logic rot,
                                         input logic [7:0] rc);
        logic [31:0] v;
        logic [31:0] r;
        v = rot ? {w[23:0], w[31:24]} : w;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sb(v[8*i +: 8]);
        r[31:24] = r[31:24] ^ rc;
        return r;
    endfunction

    function automatic int beats_of(input int d);
        return 4 >> d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on build d and wait (bounded) for its result.
    // Request inputs are scrambled right after the accept edge.
    task automatic run_req(input int d, input logic [31:0] w, input logic rot,
                           input logic [7:0] rc, output logic [31:0] got,
                           output int lat, output bit timeout);
        int n;
        in_valid[d] = 1'b1;
        in_word[d]  = w;
        in_rot[d]   = rot;
        in_rcon[d]  = rc;
        tick();
        in_valid[d] = 1'b0;
        in_word[d]  = $urandom;
        in_rot[d]   = 1'($urandom);
        in_rcon[d]  = 8'($urandom);
        n = 0;
        while (!out_valid_o[d] && n < 20) begin
            tick();
            n++;
        end
        lat     = n;
        got     = out_word_o[d];
        timeout = !out_valid_o[d];
    endtask

    task automatic release_result(input int d);
        out_ready[d] = 1'b1;
        tick();
        out_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b1;
            in_word[d]   = $urandom;
            in_rot[d]    = 1'b0;
            in_rcon[d]   = '0;
            out_ready[d] = 1'b0;
        end
        tick(); tick(); tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (in_ready_o[d] !== 1'b0 || out_valid_o[d] !== 1'b0 || out_word_o[d] !== 32'h0) begin
                failures++;
                $display("FAIL reset_state[%0d]: in_ready=%b out_valid=%b out_word=%h, expected 0 0 00000000",
                         d, in_ready_o[d], out_valid_o[d], out_word_o[d]);
            end
            in_valid[d] = 1'b0;
        end
        rst = 1'b0;
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (in_ready_o[d] !== 1'b1 || out_valid_o[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_release[%0d]: in_ready=%b out_valid=%b, expected 1 0",
                         d, in_ready_o[d], out_valid_o[d]);
            end
        end
    endtask

    task automatic test_vectors();
        logic [31:0] got;
        int lat;
        bit to;
        for (int d = 0; d < 3; d++) begin
            run_req(d, 32'h00010253, 1'b0, 8'h00, got, lat, to);
            checks++;
            if (to || got !== 32'h637C77ED || lat != beats_of(d)) begin
                failures++;
                $display("FAIL plain_subword[%0d]: got %h latency %0d, expected 637c77ed latency %0d",
                         d, got, lat, beats_of(d));
            end
            release_result(d);
            checks++;
            if (out_valid_o[d] !== 1'b0 || in_ready_o[d] !== 1'b1) begin
                failures++;
                $display("FAIL release_to_idle[%0d]: out_valid=%b in_ready=%b, expected 0 1",
                         d, out_valid_o[d], in_ready_o[d]);
            end
            run_req(d, 32'h09CF4F3C, 1'b1, 8'h01, got, lat, to);
            checks++;
            if (to || got !== 32'h8B84EB01 || lat != beats_of(d)) begin
                failures++;
                $display("FAIL key_expansion[%0d]: got %h latency %0d, expected 8b84eb01 latency %0d",
                         d, got, lat, beats_of(d));
            end
            release_result(d);
        end
    endtask

    task automatic test_random();
        logic [31:0] w, got, exp;
        logic        rot;
        logic [7:0]  rc;
        int lat;
        bit to;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 16; i++) begin
                w   = $urandom;
                rot = 1'($urandom);
                rc  = (i % 4 == 0) ? 8'h00 : 8'($urandom);
                exp = model(w, rot, rc);
                run_req(d, w, rot, rc, got, lat, to);
                checks++;
                if (to || got !== exp || lat != beats_of(d)) begin
                    failures++;
                    $display("FAIL random[%0d.%0d]: in=%h rot=%b rcon=%h got %h lat %0d, expected %h lat %0d",
                             d, i, w, rot, rc, got, lat, exp, beats_of(d));
                end
                release_result(d);
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] got, exp;
        int lat;
        bit to;
        exp = model(32'hDEADBEEF, 1'b1, 8'h36);
        run_req(0, 32'hDEADBEEF, 1'b1, 8'h36, got, lat, to);
        checks++;
        if (to || got !== exp) begin
            failures++;
            $display("FAIL hold_first[0]: got %h, expected %h", got, exp);
        end
        // a pending request during DONE must not be captured
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = 1'b1;
            in_word[0]  = $urandom;
            tick();
            checks++;
            if (out_valid_o[0] !== 1'b1 || out_word_o[0] !== exp || in_ready_o[0] !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable[%0d]: out_valid=%b out_word=%h in_ready=%b, expected 1 %h 0",
                         i, out_valid_o[0], out_word_o[0], in_ready_o[0], exp);
            end
        end
        in_valid[0] = 1'b0;
        release_result(0);
        checks++;
        if (out_valid_o[0] !== 1'b0 || in_ready_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b, expected 0 1",
                     out_valid_o[0], in_ready_o[0]);
        end
        tick(); tick();
        checks++;
        if (in_ready_o[0] !== 1'b1 || out_valid_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL hold_no_capture: in_ready=%b out_valid=%b, expected 1 0",
                     in_ready_o[0], out_valid_o[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        int lat;
        bit to;
        bit seen;
        // reset while build 0 is processing its third byte
        in_valid[0] = 1'b1;
        in_word[0]  = $urandom;
        tick();
        in_valid[0] = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_ready: in_ready=%b, expected 0", in_ready_o[0]);
        end
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid_o[0] !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen || in_ready_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL rst_busy_drop: out_valid_seen=%b in_ready=%b, expected 0 1",
                     seen, in_ready_o[0]);
        end
        run_req(0, 32'h00000000, 1'b0, 8'h00, got, lat, to);
        checks++;
        if (to || got !== 32'h63636363) begin
            failures++;
            $display("FAIL rst_then_zero: got %h, expected 63636363", got);
        end
        release_result(0);
        // reset while build 1 holds a result
        run_req(1, $urandom, 1'b0, 8'h5a, got, lat, to);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid_o[1] !== 1'b0 || out_word_o[1] !== 32'h0 || in_ready_o[1] !== 1'b1) begin
            failures++;
            $display("FAIL rst_done_drop: out_valid=%b out_word=%h in_ready=%b, expected 0 00000000 1",
                     out_valid_o[1], out_word_o[1], in_ready_o[1]);
        end
    endtask

    task automatic test_back_to_back(input int d);
        logic [31:0] w   [3];
        logic        r   [3];
        logic [7:0]  c   [3];
        logic [31:0] exp [3];
        int  sent, recv, t, last_t, extra;
        bit  accept;
        for (int i = 0; i < 3; i++) begin
            w[i]   = $urandom;
            r[i]   = 1'($urandom);
            c[i]   = 8'($urandom);
            exp[i] = model(w[i], r[i], c[i]);
        end
        sent = 0; recv = 0; t = 0; last_t = 0;
        out_ready[d] = 1'b1;
        in_valid[d]  = 1'b1;
        in_word[d]   = w[0];
        in_rot[d]    = r[0];
        in_rcon[d]   = c[0];
        while (recv < 3 && t < 100) begin
            if (out_valid_o[d]) begin
                checks++;
                if (out_word_o[d] !== exp[recv]) begin
                    failures++;
                    $display("FAIL b2b_data[%0d.%0d]: got %h, expected %h",
                             d, recv, out_word_o[d], exp[recv]);
                end
                // accept, BEATS busy cycles, one DONE cycle, one IDLE cycle
                if (recv > 0) begin
                    checks++;
                    if (t - last_t != beats_of(d) + 2) begin
                        failures++;
                        $display("FAIL b2b_spacing[%0d.%0d]: got %0d cycles, expected %0d",
                                 d, recv, t - last_t, beats_of(d) + 2);
                    end
                end
                last_t = t;
                recv++;
            end
            accept = in_ready_o[d] && in_valid[d];
            tick();
            t++;
            if (accept) begin
                sent++;
                if (sent < 3) begin
                    in_word[d] = w[sent];
                    in_rot[d]  = r[sent];
                    in_rcon[d] = c[sent];
                end else begin
                    in_valid[d] = 1'b0;
                end
            end
        end
        in_valid[d] = 1'b0;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid_o[d]) extra++;
            tick();
        end
        out_ready[d] = 1'b0;
        checks++;
        if (recv != 3 || sent != 3 || extra != 0) begin
            failures++;
            $display("FAIL b2b_count[%0d]: sent=%0d received=%0d extra=%0d, expected 3 3 0",
                     d, sent, recv, extra);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_hold();
        test_reset_mid();
        for (int d = 0; d < 3; d++) test_back_to_back(d);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 500000");
        $fatal(1);
    end
endmodule
